conv_window_accum: RTL and testbench
====================================

// Module: conv_window_accum
// PURPOSE
//  Consumes the dual-port input-feature-map read stream addressed by the conv address generator:
//  two pixels per beat (port A, port B) with matching kernel weights.
//  Multiplies, accumulates over one KxK window across all input maps, adds bias, then scales/saturates.
//  Presents one conv output per window to the output-buffer writer over a valid/ready handshake.
// PARAMETERS
//  KERNEL_WIDTH   3   kernel side K; pixels per map per window = K*K
//  IN_MAPS        2   input feature maps accumulated into one output pixel
//  DATA_WIDTH     16  signed pixel width
//  WEIGHT_WIDTH   16  signed weight width
//  ACC_WIDTH      40  signed accumulator width
//  OUT_WIDTH      16  signed output width after shift/saturate
//  FRAC_SHIFT     8   arithmetic right shift applied to (acc+bias) before saturation
// PORTS
//  clk        in   1             clock, rising edge
//  reset      in   1             asynchronous, active-high
//  in_valid   in   1             beat valid; pix/wgt sampled when high
//  pix_a      in   DATA_WIDTH    pixel from port A
//  pix_b      in   DATA_WIDTH    pixel from port B
//  wgt_a      in   WEIGHT_WIDTH  weight for pix_a
//  wgt_b      in   WEIGHT_WIDTH  weight for pix_b
//  bias       in   ACC_WIDTH     per-output bias; sampled on the window's final beat
//  out_ready  in   1             downstream accepts out_data
//  out_valid  out  1             out_data holds a result
//  out_data   out  OUT_WIDTH     conv result
//  overrun    out  1             sticky: a result was dropped while out_valid && !out_ready
//  win_count  out  16            windows completed (wraps at 2^16)
// BEHAVIOUR
//  - Reset (async): beat_cnt, map_cnt, acc, pipeline valids, out_valid, out_data, overrun, win_count all = 0.
//  - BEATS = (K*K+1)/2 per map. On the last beat of each map, lane B is masked to product 0 when K*K is odd.
//  - Counters: beat_cnt advances only on in_valid; it wraps to 0 at BEATS-1 and map_cnt increments.
//    map_cnt wraps to 0 at IN_MAPS-1, which ends the window. Gaps in in_valid hold all state.
//  - Pipeline: S1 registers inputs plus first/last tags; S2 forms two full-precision products;
//    S3 sum: acc <= (first ? 0 : acc) + pa + pb.
//    All arithmetic is sign-extended to ACC_WIDTH; acc wraps (no saturation) inside the window.
//  - Finalize (cycle after S3 of last beat): r = (acc + bias) >>> FRAC_SHIFT, clamped to
//    [-2^(OUT_WIDTH-1), 2^(OUT_WIDTH-1)-1].
//    out_data <= r, out_valid <= 1, win_count += 1.
//  - Latency: out_valid rises 4 cycles after the clk edge sampling the window's last beat.
//    Back-to-back windows are supported at full rate.
//  - Handshake: transfer when out_valid && out_ready. out_valid drops the next cycle unless a new result lands
//    that same cycle, in which case it stays high with new data.
//  - New result while out_valid && !out_ready: old data is overwritten, overrun <= 1 (sticky until reset).
//  - Reset mid-window: partial accumulation discarded; the next in_valid beat is beat 0 of map 0.
// CONFIGURATION
//  CONV_ACC_RELU_EN defined:
//    - negative saturated results are replaced by 0 before out_data.
//    - Latency is unchanged.
//  CONV_ACC_RELU_EN undefined:
//    - signed saturated result passes through unchanged.
// TESTING (K=3, IN_MAPS=2, FRAC_SHIFT=0, BEATS=5, 10 beats/window)
//  1. 10 consecutive beats, all pix=1 and wgt=1, bias=0.
//     -> one out_valid pulse with out_data=18 (lane B masked on beats 5,10); win_count=1.
//  2. Same stream, in_valid low every other cycle -> out_data=18; out_valid 4 cycles after 10th beat.
//  3. pix=1000, wgt=1000 for all beats, bias=0, OUT_WIDTH=16 -> out_data=32767 (saturated).
//     Same with wgt=-1000 -> -32768 (or 0 with CONV_ACC_RELU_EN).
//  4. Two windows back-to-back, out_ready=0 throughout.
//     -> second result overwrites first; overrun=1; out_valid stays 1.
//  5. Assert reset after beat 4 of a window, then send 10 beats of pix=2, wgt=1.
//     -> out_data=36; no stale contribution.
//  6. bias=-5, pix=1, wgt=1 -> out_data=13. FRAC_SHIFT=2 with acc=18, bias=0 -> out_data=4.

Source files
------------

// File: rtl/conv_window_accum.sv
// rtl/conv_window_accum.sv - KxK multi-map conv window MAC with bias, shift, saturate; optional ReLU via CONV_ACC_RELU_EN
module conv_window_accum #(
    parameter int KERNEL_WIDTH = 3,
    parameter int IN_MAPS      = 2,
    parameter int DATA_WIDTH   = 16,
    parameter int WEIGHT_WIDTH = 16,
    parameter int ACC_WIDTH    = 40,
    parameter int OUT_WIDTH    = 16,
    parameter int FRAC_SHIFT   = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    in_valid,
    input  logic [DATA_WIDTH-1:0]   pix_a,
    input  logic [DATA_WIDTH-1:0]   pix_b,
    input  logic [WEIGHT_WIDTH-1:0] wgt_a,
    input  logic [WEIGHT_WIDTH-1:0] wgt_b,
    input  logic [ACC_WIDTH-1:0]    bias,
    input  logic                    out_ready,
    output logic                    out_valid,
    output logic [OUT_WIDTH-1:0]    out_data,
    output logic                    overrun,
    output logic [15:0]             win_count
);

    localparam int TAPS       = KERNEL_WIDTH * KERNEL_WIDTH;
    localparam int BEATS      = (TAPS + 1) / 2;
    localparam bit ODD_TAPS   = (TAPS % 2) == 1;
    localparam int PROD_WIDTH = DATA_WIDTH + WEIGHT_WIDTH;
    localparam logic signed [ACC_WIDTH-1:0] SAT_MAX =
        ACC_WIDTH'((64'sd1 <<< (OUT_WIDTH - 1)) - 64'sd1);
    localparam logic signed [ACC_WIDTH-1:0] SAT_MIN = ~SAT_MAX;

    logic [15:0] beat_cnt;
    logic [15:0] map_cnt;
    logic        beat_last;
    logic        map_last;

    logic                           s1_valid, s1_first, s1_last, s1_mask_b;
    logic signed [DATA_WIDTH-1:0]   s1_pix_a, s1_pix_b;
    logic signed [WEIGHT_WIDTH-1:0] s1_wgt_a, s1_wgt_b;
    logic signed [ACC_WIDTH-1:0]    s1_bias;
    logic signed [PROD_WIDTH-1:0]   prod_a, prod_b;

    logic                        s2_valid, s2_first, s2_last;
    logic signed [ACC_WIDTH-1:0] s2_prod_a, s2_prod_b, s2_bias;

    logic                        s3_valid;
    logic signed [ACC_WIDTH-1:0] acc, s3_bias, biased;

    logic                        fin_valid;
    logic signed [ACC_WIDTH-1:0] fin_shift;
    logic [OUT_WIDTH-1:0]        sat_data;

    assign beat_last = (beat_cnt == 16'(BEATS - 1));
    assign map_last  = (map_cnt == 16'(IN_MAPS - 1));

    // Beat/map position inside the current window; only advances on accepted beats.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            beat_cnt <= '0;
            map_cnt  <= '0;
        end else if (in_valid) begin
            if (beat_last) begin
                beat_cnt <= '0;
                map_cnt  <= map_last ? '0 : map_cnt + 16'd1;
            end else begin
                beat_cnt <= beat_cnt + 16'd1;
            end
        end
    end

    // S1: capture operands and window position tags; bias only matters on the window's last beat.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_valid  <= 1'b0;
            s1_first  <= 1'b0;
            s1_last   <= 1'b0;
            s1_mask_b <= 1'b0;
            s1_pix_a  <= '0;
            s1_pix_b  <= '0;
            s1_wgt_a  <= '0;
            s1_wgt_b  <= '0;
            s1_bias   <= '0;
        end else begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_first  <= (beat_cnt == 16'd0) && (map_cnt == 16'd0);
                s1_last   <= beat_last && map_last;
                s1_mask_b <= ODD_TAPS && beat_last;
                s1_pix_a  <= $signed(pix_a);
                s1_pix_b  <= $signed(pix_b);
                s1_wgt_a  <= $signed(wgt_a);
                s1_wgt_b  <= $signed(wgt_b);
                if (beat_last && map_last) begin
                    s1_bias <= $signed(bias);
                end
            end
        end
    end

    assign prod_a = PROD_WIDTH'(s1_pix_a) * PROD_WIDTH'(s1_wgt_a);
    assign prod_b = PROD_WIDTH'(s1_pix_b) * PROD_WIDTH'(s1_wgt_b);

    // S2: full-precision products widened to the accumulator; lane B dropped on the odd tail tap.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s2_valid  <= 1'b0;
            s2_first  <= 1'b0;
            s2_last   <= 1'b0;
            s2_prod_a <= '0;
            s2_prod_b <= '0;
            s2_bias   <= '0;
        end else begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                s2_first  <= s1_first;
                s2_last   <= s1_last;
                s2_prod_a <= ACC_WIDTH'(prod_a);
                s2_prod_b <= s1_mask_b ? '0 : ACC_WIDTH'(prod_b);
                s2_bias   <= s1_bias;
            end
        end
    end

    // S3: wrapping accumulation, restarted by the first beat of each window.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc      <= '0;
            s3_valid <= 1'b0;
            s3_bias  <= '0;
        end else begin
            s3_valid <= s2_valid && s2_last;
            if (s2_valid) begin
                acc <= (s2_first ? '0 : acc) + s2_prod_a + s2_prod_b;
            end
            if (s2_valid && s2_last) begin
                s3_bias <= s2_bias;
            end
        end
    end

    assign biased = acc + s3_bias;

    // Finalize: add bias and scale down once the window total is complete.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fin_valid <= 1'b0;
            fin_shift <= '0;
        end else begin
            fin_valid <= s3_valid;
            if (s3_valid) begin
                fin_shift <= biased >>> FRAC_SHIFT;
            end
        end
    end

    // Clamp to the signed output range, optionally rectifying negatives.
    always_comb begin
        sat_data = fin_shift[OUT_WIDTH-1:0];
        if (fin_shift > SAT_MAX) begin
            sat_data = SAT_MAX[OUT_WIDTH-1:0];
        end else if (fin_shift < SAT_MIN) begin
            sat_data = SAT_MIN[OUT_WIDTH-1:0];
        end
`ifdef CONV_ACC_RELU_EN
        if (sat_data[OUT_WIDTH-1]) begin
            sat_data = '0;
        end
`else
        sat_data = sat_data;
`endif
    end

    // Output holding register: new results always win, dropping an unaccepted one flags overrun.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            overrun   <= 1'b0;
            win_count <= '0;
        end else if (fin_valid) begin
            out_valid <= 1'b1;
            out_data  <= sat_data;
            win_count <= win_count + 16'd1;
            if (out_valid && !out_ready) begin
                overrun <= 1'b1;
            end
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_conv_window_accum.sv
// tb/tb_conv_window_accum.sv - self-checking bench for conv_window_accum (FRAC_SHIFT 0 and 2 instances)
module tb_conv_window_accum;

    localparam int K     = 3;
    localparam int BEATS = (K * K + 1) / 2;
    localparam int BPW   = BEATS * 2;

    logic               clk = 1'b0;
    logic               reset = 1'b1;
    logic               in_valid = 1'b0;
    logic signed [15:0] pix_a = '0, pix_b = '0, wgt_a = '0, wgt_b = '0;
    logic signed [39:0] bias = '0;
    logic               out_ready = 1'b1;
    logic               out_valid0, out_valid2, overrun0, overrun2;
    logic [15:0]        out_data0, out_data2, win_count0, win_count2;

    int checks = 0;
    int failures = 0;
    bit rnd = 1'b0;

    always #5 clk = ~clk;

    conv_window_accum #(.FRAC_SHIFT(0)) dut0 (
        .clk(clk), .reset(reset), .in_valid(in_valid),
        .pix_a(pix_a), .pix_b(pix_b), .wgt_a(wgt_a), .wgt_b(wgt_b), .bias(bias),
        .out_ready(out_ready), .out_valid(out_valid0), .out_data(out_data0),
        .overrun(overrun0), .win_count(win_count0)
    );

    conv_window_accum #(.FRAC_SHIFT(2)) dut2 (
        .clk(clk), .reset(reset), .in_valid(in_valid),
        .pix_a(pix_a), .pix_b(pix_b), .wgt_a(wgt_a), .wgt_b(wgt_b), .bias(bias),
        .out_ready(out_ready), .out_valid(out_valid2), .out_data(out_data2),
        .overrun(overrun2), .win_count(win_count2)
    );

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
        end
    endtask

    typedef struct {
        int                 due;
        logic signed [15:0] r0;
        logic signed [15:0] r2;
    } res_t;

    res_t               pend[$];
    res_t               popped;
    int                 cyc = 0;
    int                 m_idx = 0;
    longint             m_sum = 0;
    logic               ev = 1'b0, eovr = 1'b0;
    logic [15:0]        ewin = '0;
    logic signed [15:0] ed0 = '0, ed2 = '0;

    function automatic logic signed [15:0] finish_val(input longint s, input longint b, input int fs);
        logic signed [39:0] t;
        longint v;
        t = 40'(s + b);
        v = longint'(t) >>> fs;
        if (v > 32767) v = 32767;
        else if (v < -32768) v = -32768;
`ifdef CONV_ACC_RELU_EN
        if (v < 0) v = 0;
`endif
        return 16'(v);
    endfunction

    // Reference: sum every tap of the window, emit 4 cycles later, track the output handshake.
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            pend.delete();
            m_idx = 0;
            m_sum = 0;
            ev = 1'b0;
            eovr = 1'b0;
            ewin = '0;
            ed0 = '0;
            ed2 = '0;
        end else begin
            cyc++;
            if (pend.size() > 0 && pend[0].due == cyc) begin
                popped = pend.pop_front();
                if (ev && !out_ready) eovr = 1'b1;
                ev = 1'b1;
                ed0 = popped.r0;
                ed2 = popped.r2;
                ewin = ewin + 16'd1;
            end else if (ev && out_ready) begin
                ev = 1'b0;
            end
            if (in_valid) begin
                m_sum += longint'(pix_a) * longint'(wgt_a);
                if (!(((K * K) % 2 == 1) && (m_idx % BEATS == BEATS - 1)))
                    m_sum += longint'(pix_b) * longint'(wgt_b);
                m_idx++;
                if (m_idx == BPW) begin
                    pend.push_back('{cyc + 4, finish_val(m_sum, longint'(bias), 0),
                                    finish_val(m_sum, longint'(bias), 2)});
                    m_idx = 0;
                    m_sum = 0;
                end
            end
        end
    end

    // Compare both instances against the reference on every cycle out of reset.
    always @(negedge clk) begin
        if (!reset) begin
            chk("out_valid0", int'(out_valid0), int'(ev));
            chk("out_valid2", int'(out_valid2), int'(ev));
            chk("overrun0", int'(overrun0), int'(eovr));
            chk("overrun2", int'(overrun2), int'(eovr));
            chk("win_count0", int'(win_count0), int'(ewin));
            chk("win_count2", int'(win_count2), int'(ewin));
            if (ev) begin
                chk("out_data0", int'($signed(out_data0)), int'(ed0));
                chk("out_data2", int'($signed(out_data2)), int'(ed2));
            end
        end
    end

    task automatic beat(input logic signed [15:0] pa, input logic signed [15:0] pb,
                        input logic signed [15:0] wa, input logic signed [15:0] wb,
                        input logic signed [39:0] b);
        in_valid = 1'b1;
        pix_a = pa;
        pix_b = pb;
        wgt_a = wa;
        wgt_b = wb;
        bias = b;
        if (rnd) out_ready = 1'($urandom_range(0, 1));
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            if (rnd) out_ready = 1'($urandom_range(0, 1));
            @(posedge clk);
            #1;
        end
    endtask

    task automatic window(input logic signed [15:0] p, input logic signed [15:0] w,
                          input logic signed [39:0] b, input bit gap);
        for (int i = 0; i < BPW; i++) begin
            beat(p, p, w, w, b);
            if (gap && i < BPW - 1) idle(1);
        end
    endtask

    task automatic wait_valid(output int n);
        n = 0;
        while (n < 20) begin
            @(posedge clk);
            n++;
            #1;
            if (out_valid0) break;
        end
        chk("wait_out_valid", int'(out_valid0), 1);
    endtask

    int lat;

    initial begin
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        chk("rst_out_valid", int'(out_valid0), 0);
        chk("rst_out_data", int'(out_data0), 0);
        chk("rst_overrun", int'(overrun0), 0);
        chk("rst_win_count", int'(win_count0), 0);
        @(posedge clk);
        #1;

        window(16'sd1, 16'sd1, 40'sd0, 1'b0);
        wait_valid(lat);
        chk("t1_latency", lat, 4);
        chk("t1_data", int'($signed(out_data0)), 18);
        chk("t1_data_fs2", int'($signed(out_data2)), 4);
        chk("t1_win_count", int'(win_count0), 1);
        idle(2);

        window(16'sd1, 16'sd1, 40'sd0, 1'b1);
        wait_valid(lat);
        chk("t2_latency", lat, 4);
        chk("t2_data", int'($signed(out_data0)), 18);
        idle(2);

        window(16'sd1000, 16'sd1000, 40'sd0, 1'b0);
        wait_valid(lat);
        chk("t3_sat_pos", int'($signed(out_data0)), 32767);
        chk("t3_sat_pos_fs2", int'($signed(out_data2)), 32767);
        idle(2);
        window(16'sd1000, -16'sd1000, 40'sd0, 1'b0);
        wait_valid(lat);
`ifdef CONV_ACC_RELU_EN
        chk("t3_sat_neg", int'($signed(out_data0)), 0);
`else
        chk("t3_sat_neg", int'($signed(out_data0)), -32768);
`endif
        idle(2);

        window(16'sd1, 16'sd1, -40'sd5, 1'b0);
        wait_valid(lat);
        chk("t6_bias", int'($signed(out_data0)), 13);
        chk("t6_bias_fs2", int'($signed(out_data2)), 3);
        idle(2);

        out_ready = 1'b0;
        window(16'sd1, 16'sd1, 40'sd0, 1'b0);
        window(16'sd2, 16'sd1, 40'sd0, 1'b0);
        idle(6);
        chk("t4_out_valid", int'(out_valid0), 1);
        chk("t4_overrun", int'(overrun0), 1);
        chk("t4_data", int'($signed(out_data0)), 36);
        out_ready = 1'b1;
        idle(2);
        chk("t4_drained", int'(out_valid0), 0);

        for (int i = 0; i < 4; i++) beat(16'sd7, 16'sd7, 16'sd3, 16'sd3, 40'sd0);
        reset = 1'b1;
        idle(2);
        reset = 1'b0;
        chk("t5_overrun_cleared", int'(overrun0), 0);
        chk("t5_win_count_cleared", int'(win_count0), 0);
        window(16'sd2, 16'sd1, 40'sd0, 1'b0);
        wait_valid(lat);
        chk("t5_data", int'($signed(out_data0)), 36);
        chk("t5_data_fs2", int'($signed(out_data2)), 9);
        idle(2);

        rnd = 1'b1;
        for (int w = 0; w < 40; w++) begin
            for (int b = 0; b < BPW; b++) begin
                if (w % 2 == 0)
                    beat(16'($urandom_range(0, 128)) - 16'sd64, 16'($urandom_range(0, 128)) - 16'sd64,
                         16'($urandom_range(0, 128)) - 16'sd64, 16'($urandom_range(0, 128)) - 16'sd64,
                         40'(int'($urandom_range(0, 1 << 20)) - (1 << 19)));
                else
                    beat(16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom),
                         40'(int'($urandom_range(0, 1 << 20)) - (1 << 19)));
                if ($urandom_range(0, 3) == 0) idle(int'($urandom_range(1, 3)));
            end
            if ($urandom_range(0, 3) == 0) idle(int'($urandom_range(1, 6)));
        end
        rnd = 1'b0;
        out_ready = 1'b1;
        idle(10);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
